// File: rtl/prbs_pkg.sv
// Shared PRBS7 definitions: register width, default seed, FSM state
// encoding and the LFSR next-state function.
package prbs_pkg;

  localparam int PRBS_W = 7;
  localparam logic [PRBS_W-1:0] PRBS_SEED = 7'h6C;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } bert_state_e;

  // One PRBS7 step: shift right, the new MSB is s[0]^s[1]; output bit is s[0].
  function automatic logic [PRBS_W-1:0] prbs7_next(input logic [PRBS_W-1:0] s);
    return {s[0] ^ s[1], s[PRBS_W-1:1]};
  endfunction

endpackage

// File: rtl/prbs_bert_ctrl_if.sv
// Control/status and serial datapath bundle of the PRBS7 BER tester.
// Optional macro PRBS_ERR_INJECT_EN adds the inj_err input.
interface prbs_bert_ctrl_if #(
  parameter int CNT_W = 32,
  parameter int ERR_W = 16
);

  logic             start;
  logic             abort;
  logic [CNT_W-1:0] num_bits;
  logic             rx_bit;
  logic             rx_valid;
`ifdef PRBS_ERR_INJECT_EN
  logic             inj_err;
`endif
  logic             tx_bit;
  logic             tx_valid;
  logic             busy;
  logic             locked;
  logic             done;
  logic [CNT_W-1:0] bit_cnt;
  logic [ERR_W-1:0] err_cnt;
  logic             err_sat;

  // Register-interface / PHY side: drives requests and received data.
  modport master (
    output start, abort, num_bits, rx_bit, rx_valid,
    input  tx_bit, tx_valid, busy, locked, done, bit_cnt, err_cnt, err_sat
`ifdef PRBS_ERR_INJECT_EN
    , output inj_err
`endif
  );

  // BER tester side.
  modport slave (
    input  start, abort, num_bits, rx_bit, rx_valid,
    output tx_bit, tx_valid, busy, locked, done, bit_cnt, err_cnt, err_sat
`ifdef PRBS_ERR_INJECT_EN
    , input inj_err
`endif
  );

endinterface

// File: rtl/prbs7_lfsr.sv
// Loadable PRBS7 generator. The serial output bit is state[0].
module prbs7_lfsr
  import prbs_pkg::*;
#(
  parameter logic [PRBS_W-1:0] RST_VAL = PRBS_SEED
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [PRBS_W-1:0] seed,
  input  logic              en,
  output logic [PRBS_W-1:0] state
);

  logic [PRBS_W-1:0] state_q, state_d;

  // Load wins over stepping; otherwise hold.
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = seed;
    end else if (en) begin
      state_d = prbs7_next(state_q);
    end
  end

  // LFSR register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RST_VAL;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/prbs_bert_ctrl.sv
// PRBS7 bit-error-rate test sequencer: runs a local PRBS7 transmitter,
// self-synchronises a checker to the received stream, counts checked bits
// and (saturating) errors over a programmed length, then pulses done.
// Optional macro PRBS_ERR_INJECT_EN: inj_err inverts tx_bit for that cycle.
module prbs_bert_ctrl
  import prbs_pkg::*;
#(
  parameter int                CNT_W = 32,
  parameter int                ERR_W = 16,
  parameter logic [PRBS_W-1:0] SEED  = PRBS_SEED
) (
  input logic             clk,
  input logic             rst_n,
  prbs_bert_ctrl_if.slave bus
);

  localparam logic [ERR_W-1:0] ERR_MAX   = '1;
  localparam logic [2:0]       SYNC_LAST = 3'(PRBS_W - 1);

  bert_state_e       state_q, state_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
  logic              err_sat_q, err_sat_d;
  logic [PRBS_W-1:0] rx_lfsr_q, rx_lfsr_d;
  logic [2:0]        sync_cnt_q, sync_cnt_d;

  logic              start_acc;
  logic              rx_exp;
  logic              rx_err;
  logic [CNT_W-1:0]  bit_cnt_inc;
  logic [ERR_W-1:0]  err_cnt_inc;
  logic              busy_c, locked_c, done_c, tx_valid_c, tx_bit_c;
  logic [PRBS_W-1:0] tx_lfsr_state;

  // abort beats start even in IDLE.
  assign start_acc   = (state_q == IDLE) && bus.start && !bus.abort;
  assign rx_exp      = rx_lfsr_q[0] ^ rx_lfsr_q[1];
  assign rx_err      = bus.rx_bit != rx_exp;
  assign bit_cnt_inc = bit_cnt_q + CNT_W'(1);
  assign err_cnt_inc = err_cnt_q + ERR_W'(1);

  prbs7_lfsr #(
    .RST_VAL (SEED)
  ) u_tx_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (start_acc),
    .seed  (SEED),
    .en    (tx_valid_c),
    .state (tx_lfsr_state)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; abort out of any active state takes priority.
  always_comb begin
    state_d = state_q;
    if (state_q != IDLE && bus.abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:  if (start_acc) state_d = SYNC;
        SYNC:  if (bus.rx_valid && sync_cnt_q == SYNC_LAST)
                 state_d = (len_q == '0) ? DONE : CHECK;
        CHECK: if (bus.rx_valid && bit_cnt_inc == len_q) state_d = DONE;
        DONE:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM outputs; tx_bit is forced low whenever it is not qualified.
  always_comb begin
    busy_c     = state_q != IDLE;
    locked_c   = state_q == CHECK;
    done_c     = state_q == DONE;
    tx_valid_c = (state_q == SYNC) || (state_q == CHECK);
`ifdef PRBS_ERR_INJECT_EN
    tx_bit_c   = tx_valid_c & (tx_lfsr_state[0] ^ bus.inj_err);
`else
    tx_bit_c   = tx_valid_c & tx_lfsr_state[0];
`endif
  end

  // Checker datapath: sync shift-in, then self-predicting compare. The
  // predicted bit (not the received one) is fed back so a single bit error
  // never corrupts later predictions. Counters hold outside an active test.
  always_comb begin
    len_d      = len_q;
    bit_cnt_d  = bit_cnt_q;
    err_cnt_d  = err_cnt_q;
    err_sat_d  = err_sat_q;
    rx_lfsr_d  = rx_lfsr_q;
    sync_cnt_d = sync_cnt_q;
    if (start_acc) begin
      len_d      = bus.num_bits;
      bit_cnt_d  = '0;
      err_cnt_d  = '0;
      err_sat_d  = 1'b0;
      rx_lfsr_d  = '0;
      sync_cnt_d = '0;
    end else if (!bus.abort && bus.rx_valid) begin
      case (state_q)
        SYNC: begin
          rx_lfsr_d  = {bus.rx_bit, rx_lfsr_q[PRBS_W-1:1]};
          sync_cnt_d = sync_cnt_q + 3'd1;
        end
        CHECK: begin
          rx_lfsr_d = {rx_exp, rx_lfsr_q[PRBS_W-1:1]};
          bit_cnt_d = bit_cnt_inc;
          if (rx_err && err_cnt_q != ERR_MAX) begin
            err_cnt_d = err_cnt_inc;
            if (err_cnt_inc == ERR_MAX) err_sat_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Checker datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q      <= '0;
      bit_cnt_q  <= '0;
      err_cnt_q  <= '0;
      err_sat_q  <= 1'b0;
      rx_lfsr_q  <= '0;
      sync_cnt_q <= '0;
    end else begin
      len_q      <= len_d;
      bit_cnt_q  <= bit_cnt_d;
      err_cnt_q  <= err_cnt_d;
      err_sat_q  <= err_sat_d;
      rx_lfsr_q  <= rx_lfsr_d;
      sync_cnt_q <= sync_cnt_d;
    end
  end

  assign bus.tx_bit   = tx_bit_c;
  assign bus.tx_valid = tx_valid_c;
  assign bus.busy     = busy_c;
  assign bus.locked   = locked_c;
  assign bus.done     = done_c;
  assign bus.bit_cnt  = bit_cnt_q;
  assign bus.err_cnt  = err_cnt_q;
  assign bus.err_sat  = err_sat_q;

endmodule

// File: tb/tb_prbs_bert_ctrl.sv
// Self-checking bench for prbs_bert_ctrl: loopback, random streams with gaps
// and errors against a recurrence-based reference, saturation (ERR_W=4
// instance), abort, zero length, ignored starts and asynchronous reset.
// Build with PRBS_ERR_INJECT_EN to also exercise inj_err.
`timescale 1ns/1ps
module tb_prbs_bert_ctrl;

  localparam int CNT_W  = 32;
  localparam int ERR_W  = 16;
  localparam int ERR_W2 = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prbs_bert_ctrl_if #(.CNT_W(CNT_W), .ERR_W(ERR_W))  bus ();
  prbs_bert_ctrl_if #(.CNT_W(CNT_W), .ERR_W(ERR_W2)) bus2 ();

  prbs_bert_ctrl #(.CNT_W(CNT_W), .ERR_W(ERR_W), .SEED(7'h6C)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  prbs_bert_ctrl #(.CNT_W(CNT_W), .ERR_W(ERR_W2), .SEED(7'h6C)) dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  bit sent_q[$];   // every valid bit handed to rx, in order
  bit tx_q[$];     // every qualified tx bit observed
  bit src_q[$];    // random-mode source stream
  bit ref_q[$];    // reference PRBS7 sequence
  int lock_bad;

  // Reference PRBS7 from a seed: first 7 bits are seed[0..6], then
  // b[k] = b[k-7] ^ b[k-6].
  function automatic void gen_ref(input logic [6:0] seed, input int n);
    ref_q.delete();
    for (int k = 0; k < n; k++) begin
      if (k < 7) ref_q.push_back(seed[k]);
      else       ref_q.push_back(ref_q[k-7] ^ ref_q[k-6]);
    end
  endfunction

  // Checker reference: the first 7 received bits seed a predicted stream
  // following the PRBS7 recurrence; each of the next len bits is an error
  // where it differs from the prediction. Errors saturate at 2^errw-1.
  function automatic void bert_model(input int len, input int errw,
                                     output int exp_n, output int exp_err,
                                     output bit exp_sat);
    bit e[$];
    int errs = 0;
    int maxv = (1 << errw) - 1;
    exp_n = 7 + len;
    for (int n = 0; n < exp_n && n < sent_q.size(); n++) begin
      if (n < 7) e.push_back(sent_q[n]);
      else begin
        e.push_back(e[n-7] ^ e[n-6]);
        if (sent_q[n] != e[n]) errs++;
      end
    end
    exp_err = (errs > maxv) ? maxv : errs;
    exp_sat = errs >= maxv;
  endfunction

  task automatic start_test(input int n);
    bus.num_bits = n;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
  endtask

  // Drives rx until done is seen or budget cycles pass.
  // mode 0: loopback of tx; mode 1: src_q with random gaps.
  // flip_idx: invert that valid bit; inj_idx: pulse inj_err there;
  // restart_idx: issue a (to-be-ignored) start there.
  task automatic drive(input int mode, input int flip_idx, input int inj_idx,
                       input int restart_idx, input int gap_pct, input int budget,
                       output int nrx, output bit got_done);
    int src_i = 0;
    int cyc   = 0;
    bit v, b;
    nrx = 0; got_done = 1'b0; lock_bad = 0;
    sent_q.delete(); tx_q.delete();
    while (cyc < budget) begin
      if (bus.done === 1'b1) begin
        got_done = 1'b1;
        break;
      end
      if (bus.busy !== 1'b1 || bus.tx_valid !== 1'b1 || bus.locked !== (nrx >= 7))
        lock_bad++;
`ifdef PRBS_ERR_INJECT_EN
      bus.inj_err = (nrx == inj_idx);
`endif
      if (nrx == restart_idx) begin
        bus.start = 1'b1;
        bus.num_bits = 5;
      end else begin
        bus.start = 1'b0;
      end
      #1;
      tx_q.push_back(bus.tx_bit);
      if (mode == 0) begin
        v = 1'b1;
        b = bus.tx_bit;
      end else begin
        v = ($urandom_range(99) >= gap_pct);
        b = src_q[src_i];
      end
      if (v && nrx == flip_idx) b = ~b;
      bus.rx_valid = v;
      bus.rx_bit   = v ? b : 1'($urandom_range(1));
      if (v) begin
        sent_q.push_back(b);
        nrx++;
        if (mode != 0) src_i++;
      end
      @(negedge clk);
      cyc++;
    end
    bus.rx_valid = 1'b0;
    bus.start    = 1'b0;
`ifdef PRBS_ERR_INJECT_EN
    bus.inj_err  = 1'b0;
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.locked, bus.done, bus.tx_valid, bus.tx_bit, bus.err_sat} !== 6'b0 ||
        bus.bit_cnt !== 0 || bus.err_cnt !== 0)
      $display("FAIL reset_outputs: got busy=%b locked=%b done=%b txv=%b tx=%b sat=%b bc=%0d ec=%0d, want all 0",
               bus.busy, bus.locked, bus.done, bus.tx_valid, bus.tx_bit, bus.err_sat, bus.bit_cnt, bus.err_cnt);
    else n_pass++;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.rx_valid = 1'b1;
      bus.rx_bit   = 1'($urandom_range(1));
      @(negedge clk);
    end
    bus.rx_valid = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.tx_valid !== 1'b0 || bus.bit_cnt !== 0)
      $display("FAIL idle_ignores_rx: got busy=%b txv=%b bc=%0d, want 0 0 0",
               bus.busy, bus.tx_valid, bus.bit_cnt);
    else n_pass++;
  endtask

  task automatic test_loopback();
    int nrx, bad;
    bit got;
    logic [6:0] first7;
    start_test(100);
    drive(0, -1, -1, -1, 0, 400, nrx, got);
    n_checks++;
    if (!got) $display("FAIL loop_done: got no done, want done");
    else n_pass++;
    n_checks++;
    if (nrx !== 107) $display("FAIL loop_rx_bits: got %0d, want 107", nrx);
    else n_pass++;
    n_checks++;
    if (bus.bit_cnt !== 100 || bus.err_cnt !== 0 || bus.err_sat !== 1'b0)
      $display("FAIL loop_counters: got bc=%0d ec=%0d sat=%b, want 100 0 0",
               bus.bit_cnt, bus.err_cnt, bus.err_sat);
    else n_pass++;
    first7 = '0;
    for (int i = 0; i < 7 && i < tx_q.size(); i++) first7[6-i] = tx_q[i];
    n_checks++;
    if (first7 !== 7'b0011011) $display("FAIL loop_first_tx: got %b, want 0011011", first7);
    else n_pass++;
    gen_ref(7'h6C, tx_q.size());
    bad = 0;
    for (int i = 0; i < tx_q.size(); i++) if (tx_q[i] != ref_q[i]) bad++;
    n_checks++;
    if (bad !== 0 || tx_q.size() < 100)
      $display("FAIL loop_tx_seq: got %0d mismatches over %0d bits, want 0 over >=100", bad, tx_q.size());
    else n_pass++;
    n_checks++;
    if (lock_bad !== 0) $display("FAIL loop_status: got %0d bad status cycles, want 0", lock_bad);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.tx_valid !== 1'b0 || bus.bit_cnt !== 100)
      $display("FAIL loop_after_done: got done=%b busy=%b txv=%b bc=%0d, want 0 0 0 100",
               bus.done, bus.busy, bus.tx_valid, bus.bit_cnt);
    else n_pass++;
  endtask

  task automatic test_single_error();
    int nrx, exp_n, exp_err;
    bit got, exp_sat;
    start_test(100);
    drive(0, 16, -1, -1, 0, 400, nrx, got);
    bert_model(100, ERR_W, exp_n, exp_err, exp_sat);
    n_checks++;
    if (!got || nrx !== exp_n || bus.bit_cnt !== 100)
      $display("FAIL err1_done: got done=%b nrx=%0d bc=%0d, want 1 %0d 100", got, nrx, bus.bit_cnt, exp_n);
    else n_pass++;
    n_checks++;
    if (bus.err_cnt !== 1 || bus.err_cnt !== exp_err)
      $display("FAIL err1_count: got %0d, want 1 (model %0d)", bus.err_cnt, exp_err);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_random();
    int nrx, exp_n, exp_err, len, gap, errp;
    bit got, exp_sat;
    for (int it = 0; it < 6; it++) begin
      len  = (it == 0) ? 1 : $urandom_range(60, 2);
      gap  = $urandom_range(50);
      errp = (it == 1) ? 0 : $urandom_range(25);
      src_q.delete();
      for (int k = 0; k < 3000; k++) begin
        if (k < 7) src_q.push_back(1'($urandom_range(1)));
        else       src_q.push_back(src_q[k-7] ^ src_q[k-6]);
      end
      for (int k = 0; k < 3000; k++)
        if ($urandom_range(99) < errp) src_q[k] = ~src_q[k];
      start_test(len);
      drive(1, -1, -1, -1, gap, 2000, nrx, got);
      bert_model(len, ERR_W, exp_n, exp_err, exp_sat);
      n_checks++;
      if (!got || nrx !== exp_n)
        $display("FAIL rand%0d_done: got done=%b nrx=%0d, want 1 %0d", it, got, nrx, exp_n);
      else n_pass++;
      n_checks++;
      if (bus.bit_cnt !== len || bus.err_cnt !== exp_err || bus.err_sat !== exp_sat)
        $display("FAIL rand%0d_counters: got bc=%0d ec=%0d sat=%b, want %0d %0d %b",
                 it, bus.bit_cnt, bus.err_cnt, bus.err_sat, len, exp_err, exp_sat);
      else n_pass++;
      n_checks++;
      if (lock_bad !== 0) $display("FAIL rand%0d_status: got %0d bad cycles, want 0", it, lock_bad);
      else n_pass++;
      repeat ($urandom_range(3, 1)) @(negedge clk);
    end
  endtask

  task automatic test_saturation();
    int nrx = 0, cyc = 0, exp_n, exp_err;
    bit got = 1'b0, exp_sat, b;
    bus2.num_bits = 40;
    bus2.start    = 1'b1;
    @(negedge clk);
    bus2.start    = 1'b0;
    sent_q.delete();
    while (cyc < 400) begin
      if (bus2.done === 1'b1) begin
        got = 1'b1;
        break;
      end
      b = ~bus2.tx_bit;
      bus2.rx_valid = bus2.tx_valid;
      bus2.rx_bit   = b;
      if (bus2.tx_valid) begin
        sent_q.push_back(b);
        nrx++;
      end
      @(negedge clk);
      cyc++;
    end
    bus2.rx_valid = 1'b0;
    bert_model(40, ERR_W2, exp_n, exp_err, exp_sat);
    n_checks++;
    if (!got || nrx !== exp_n || bus2.bit_cnt !== 40)
      $display("FAIL sat_done: got done=%b nrx=%0d bc=%0d, want 1 %0d 40", got, nrx, bus2.bit_cnt, exp_n);
    else n_pass++;
    n_checks++;
    if (bus2.err_cnt !== exp_err || bus2.err_cnt !== 4'hF)
      $display("FAIL sat_count: got %0d, want 15 (model %0d)", bus2.err_cnt, exp_err);
    else n_pass++;
    n_checks++;
    if (bus2.err_sat !== exp_sat || bus2.err_sat !== 1'b1)
      $display("FAIL sat_flag: got %b, want 1", bus2.err_sat);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_abort();
    int nrx;
    bit got, seen_done = 1'b0;
    start_test(100);
    drive(0, 12, -1, -1, 0, 27, nrx, got);
    n_checks++;
    if (bus.bit_cnt !== 20 || bus.err_cnt !== 1 || bus.locked !== 1'b1)
      $display("FAIL abort_pre: got bc=%0d ec=%0d locked=%b, want 20 1 1",
               bus.bit_cnt, bus.err_cnt, bus.locked);
    else n_pass++;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.locked !== 1'b0 || bus.tx_valid !== 1'b0)
      $display("FAIL abort_idle: got busy=%b done=%b locked=%b txv=%b, want 0 0 0 0",
               bus.busy, bus.done, bus.locked, bus.tx_valid);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      if (bus.done === 1'b1) seen_done = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (seen_done || bus.bit_cnt !== 20 || bus.err_cnt !== 1)
      $display("FAIL abort_hold: got done_seen=%b bc=%0d ec=%0d, want 0 20 1",
               seen_done, bus.bit_cnt, bus.err_cnt);
    else n_pass++;
    start_test(5);
    n_checks++;
    if (bus.bit_cnt !== 0 || bus.err_cnt !== 0 || bus.busy !== 1'b1)
      $display("FAIL abort_restart_clear: got bc=%0d ec=%0d busy=%b, want 0 0 1",
               bus.bit_cnt, bus.err_cnt, bus.busy);
    else n_pass++;
    drive(0, -1, -1, -1, 0, 100, nrx, got);
    n_checks++;
    if (!got || bus.bit_cnt !== 5 || nrx !== 12)
      $display("FAIL abort_rerun: got done=%b bc=%0d nrx=%0d, want 1 5 12", got, bus.bit_cnt, nrx);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_zero_len();
    int nrx;
    bit got;
    start_test(0);
    drive(0, -1, -1, -1, 0, 50, nrx, got);
    n_checks++;
    if (!got || nrx !== 7 || bus.bit_cnt !== 0 || bus.err_cnt !== 0 || lock_bad !== 0)
      $display("FAIL zero_len: got done=%b nrx=%0d bc=%0d ec=%0d bad=%0d, want 1 7 0 0 0",
               got, nrx, bus.bit_cnt, bus.err_cnt, lock_bad);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_start_abort_idle();
    bus.num_bits = 50;
    bus.start    = 1'b1;
    bus.abort    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.abort    = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.tx_valid !== 1'b0)
      $display("FAIL start_abort_idle: got busy=%b txv=%b, want 0 0", bus.busy, bus.tx_valid);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int nrx;
    bit got;
    start_test(30);
    drive(0, -1, -1, 3, 0, 200, nrx, got);
    n_checks++;
    if (!got || nrx !== 37 || bus.bit_cnt !== 30)
      $display("FAIL busy_start_ignored: got done=%b nrx=%0d bc=%0d, want 1 37 30", got, nrx, bus.bit_cnt);
    else n_pass++;
    bus.num_bits = 8;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.bit_cnt !== 30)
      $display("FAIL done_start_ignored: got busy=%b bc=%0d, want 0 30", bus.busy, bus.bit_cnt);
    else n_pass++;
    start_test(12);
    drive(0, -1, -1, -1, 0, 100, nrx, got);
    n_checks++;
    if (!got || nrx !== 19 || bus.bit_cnt !== 12 || bus.err_cnt !== 0)
      $display("FAIL back_to_back: got done=%b nrx=%0d bc=%0d ec=%0d, want 1 19 12 0",
               got, nrx, bus.bit_cnt, bus.err_cnt);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    int nrx;
    bit got;
    start_test(100);
    drive(0, 12, -1, -1, 0, 40, nrx, got);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.busy, bus.locked, bus.done, bus.tx_valid, bus.tx_bit, bus.err_sat} !== 6'b0 ||
        bus.bit_cnt !== 0 || bus.err_cnt !== 0)
      $display("FAIL async_reset: got busy=%b locked=%b done=%b txv=%b tx=%b sat=%b bc=%0d ec=%0d, want all 0",
               bus.busy, bus.locked, bus.done, bus.tx_valid, bus.tx_bit, bus.err_sat, bus.bit_cnt, bus.err_cnt);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0)
      $display("FAIL async_reset_idle: got busy=%b done=%b, want 0 0", bus.busy, bus.done);
    else n_pass++;
  endtask

`ifdef PRBS_ERR_INJECT_EN
  task automatic test_inject();
    int nrx, exp_n, exp_err, bad;
    bit got, exp_sat;
    start_test(50);
    drive(0, -1, 20, -1, 0, 200, nrx, got);
    bert_model(50, ERR_W, exp_n, exp_err, exp_sat);
    n_checks++;
    if (!got || bus.bit_cnt !== 50 || bus.err_cnt !== 1 || bus.err_cnt !== exp_err)
      $display("FAIL inject: got done=%b bc=%0d ec=%0d, want 1 50 1 (model %0d)",
               got, bus.bit_cnt, bus.err_cnt, exp_err);
    else n_pass++;
    gen_ref(7'h6C, tx_q.size());
    bad = 0;
    for (int i = 0; i < tx_q.size(); i++) if (tx_q[i] != ref_q[i]) bad++;
    n_checks++;
    if (bad !== 1) $display("FAIL inject_tx_only: got %0d tx mismatches, want 1", bad);
    else n_pass++;
    @(negedge clk);
  endtask
`endif

  initial begin
    bus.start = 1'b0;  bus.abort = 1'b0;  bus.num_bits = '0;
    bus.rx_bit = 1'b0; bus.rx_valid = 1'b0;
    bus2.start = 1'b0; bus2.abort = 1'b0; bus2.num_bits = '0;
    bus2.rx_bit = 1'b0; bus2.rx_valid = 1'b0;
`ifdef PRBS_ERR_INJECT_EN
    bus.inj_err = 1'b0;
    bus2.inj_err = 1'b0;
`endif
    test_reset();
    test_loopback();
    test_single_error();
    test_random();
    test_saturation();
    test_abort();
    test_zero_len();
    test_start_abort_idle();
    test_back_to_back();
    test_async_reset();
`ifdef PRBS_ERR_INJECT_EN
    test_inject();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_checks);
    $fatal(1, "timeout");
  end

endmodule
